// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM encoding, index-width helper and default watchdog timeout for fifo arbiters
package fifo_arb_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    localparam int DEFAULT_TIMEOUT = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request scanning ptr+1, ptr+2, ... with wrap
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W:0] s;

    // scan from the farthest slot to the nearest so the nearest set request is the last one written
    always_comb begin
        found = 1'b0;
        idx = '0;
        s = '0;
        for (int k = N; k >= 1; k--) begin
            s = {1'b0, ptr} + (W+1)'(k);
            s = (s >= (W+1)'(N)) ? s - (W+1)'(N) : s;
            if (req[s[W-1:0]]) begin
                found = 1'b1;
                idx = s[W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locked arbiter sharing one fifo write port; ARB_WATCHDOG_EN adds a stall watchdog
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                          CLKEXT,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_LAST,
    output logic [NUM_REQ-1:0]            GNT,
    input  logic                          FIFO_FULL,
    output logic                          FIFO_WR_EN,
    output logic [DATA_WIDTH-1:0]         FIFO_DATA_IN,
    output logic [idx_w(NUM_REQ)-1:0]     OWNER,
    output logic                          BUSY,
    output logic                          ERR_TIMEOUT
);

    localparam int W = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
    end

    logic [0:0]   state;
    logic [W-1:0] ptr;
    logic         found;
    logic [W-1:0] pick;
    logic         acc;
    logic         rel;
    logic         to;

    rr_pick #(.N(NUM_REQ), .W(W)) u_pick (
        .req   (REQ),
        .ptr   (ptr),
        .found (found),
        .idx   (pick)
    );

    assign BUSY         = (state == XFER);
    assign acc          = ~RST & BUSY & REQ[OWNER] & ~FIFO_FULL & ~to;
    assign rel          = (acc & REQ_LAST[OWNER]) | to;
    assign GNT          = {{(NUM_REQ-1){1'b0}}, acc} << OWNER;
    assign FIFO_WR_EN   = acc;
    assign FIFO_DATA_IN = BUSY ? REQ_DATA[OWNER*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign ERR_TIMEOUT  = to;

`ifdef ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] stall;

    assign to = ~RST & BUSY & (stall == CW'(TIMEOUT));

    // count cycles the owner leaves REQ low; a full fifo with REQ held is not a stall
    always_ff @(posedge CLKEXT) begin
        stall <= (RST | ~BUSY | acc | to) ? '0 : ~REQ[OWNER] ? stall + 1'b1 : stall;
    end
`else
    assign to = 1'b0;
`endif

    // IDLE latches the next owner round-robin; XFER holds it until its last beat or a forced release
    always_ff @(posedge CLKEXT) begin
        if (RST) begin
            state <= IDLE;
            ptr   <= W'(NUM_REQ - 1);
            OWNER <= '0;
        end else if (!BUSY) begin
            if (found) begin
                OWNER <= pick;
                state <= XFER;
            end
        end else if (rel) begin
            ptr   <= OWNER;
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench; producer queues drive the arbiter, a monitor pops expected beats on each fifo write
module tb_fifo_wr_arbiter;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct packed {
        logic [1:0] i;
        logic [7:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  gnt;
    logic        full;
    logic        wr_en;
    logic [7:0]  din;
    logic [1:0]  owner;
    logic        busy;
    logic        err;

    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    beat_t pq[4][$];
    exp_t  exp_q[$];
    exp_t  mon_e;
    int    wr_cyc[$];
    int    err_cyc[$];
    logic [3:0] gnt_seen = '0;
    logic [3:0] dead = '0;
    bit    use_fifo = 0;
    int    fifo_cnt = 0;
    int    rd_pend = 0;
    int    c;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
        .CLKEXT       (clk),
        .RST          (rst),
        .REQ          (req),
        .REQ_DATA     (req_data),
        .REQ_LAST     (req_last),
        .GNT          (gnt),
        .FIFO_FULL    (full),
        .FIFO_WR_EN   (wr_en),
        .FIFO_DATA_IN (din),
        .OWNER        (owner),
        .BUSY         (busy),
        .ERR_TIMEOUT  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic push_pkt(input int p, input int n, input int base, input int nexp);
        beat_t b;
        exp_t  e;
        for (int k = 0; k < n; k++) begin
            b.d = 8'(base + k);
            b.l = (k == n - 1);
            pq[p].push_back(b);
            if (k < nexp) begin
                e.i = 2'(p);
                e.d = 8'(base + k);
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        gnt_seen = gnt;
        if (err) err_cyc.push_back(cyc);
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got data %0h gnt %b, required no write (cycle %0d)", din, gnt, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_gnt", int'(gnt), 1 << mon_e.i);
                chk("wr_data", int'(din), int'(mon_e.d));
                wr_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < 4; i++)
                if (gnt_seen[i] && pq[i].size() > 0) void'(pq[i].pop_front());
            if (use_fifo) begin
                if (|gnt_seen) fifo_cnt++;
                if (rd_pend > 0 && fifo_cnt > 0) begin
                    fifo_cnt--;
                    rd_pend--;
                end
            end
            for (int i = 0; i < 4; i++) begin
                req[i] = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i] = 1'b0;
                if (pq[i].size() > 0) begin
                    req[i] = ~dead[i];
                    req_data[i*8 +: 8] = pq[i][0].d;
                    req_last[i] = pq[i][0].l;
                end
            end
            full = use_fifo && (fifo_cnt >= 8);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req = '0;
        req_data = '0;
        req_last = '0;
        full = 1'b0;
        step(2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_owner", int'(owner), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_din", int'(din), 0);
        rst = 1'b0;

        // single 3-beat packet from producer 0
        wr_cyc.delete();
        c = cyc;
        push_pkt(0, 3, 'hA0, 3);
        step(6);
        chk("p0_nwrites", wr_cyc.size(), 3);
        for (int k = 0; k < 3 && k < wr_cyc.size(); k++) chk("p0_write_cycle", wr_cyc[k], c + 2 + k);
        chk("p0_busy_after", int'(busy), 0);

        // everyone requests single-beat packets; ptr=0 after producer 0 released
        wr_cyc.delete();
        for (int r = 0; r < 2; r++) begin
            push_pkt(1, 1, 16 * (r + 1) + 1, 1);
            push_pkt(2, 1, 16 * (r + 1) + 2, 1);
            push_pkt(3, 1, 16 * (r + 1) + 3, 1);
            push_pkt(0, 1, 16 * (r + 1), 1);
        end
        step(20);
        chk("rr_nwrites", wr_cyc.size(), 8);
        for (int k = 1; k < 8 && k < wr_cyc.size(); k++) chk("rr_gap", wr_cyc[k] - wr_cyc[k-1], 2);

        // producer 2 streams 10 beats into an 8-deep fifo with no reads
        wr_cyc.delete();
        use_fifo = 1;
        fifo_cnt = 0;
        push_pkt(2, 10, 'h30, 10);
        step(20);
        chk("full_nwrites", wr_cyc.size(), 8);
        chk("full_busy", int'(busy), 1);
        chk("full_owner", int'(owner), 2);
        chk("full_gnt", int'(gnt), 0);
        rd_pend = 1;
        step(5);
        chk("full_last_held_nwrites", wr_cyc.size(), 9);
        chk("full_last_held_busy", int'(busy), 1);
        chk("full_last_held_gnt", int'(gnt), 0);
        rd_pend = 1;
        step(5);
        chk("full_done_nwrites", wr_cyc.size(), 10);
        chk("full_done_busy", int'(busy), 0);
        use_fifo = 0;
        fifo_cnt = 0;

        // producer 1 owns mid-packet; 3 and 0 request and must wait, then 3 wins over 0
        push_pkt(1, 4, 'h40, 4);
        step(2);
        chk("lock_owner", int'(owner), 1);
        chk("lock_busy", int'(busy), 1);
        push_pkt(3, 2, 'h50, 2);
        push_pkt(0, 1, 'h60, 1);
        step(12);
        chk("lock_drained", exp_q.size(), 0);

        // reset mid-packet after 2 of 5 beats
        wr_cyc.delete();
        push_pkt(3, 5, 'h70, 2);
        step(4);
        chk("rst_mid_nwrites", wr_cyc.size(), 2);
        rst = 1'b1;
        pq[3].delete();
        step(1);
        rst = 1'b0;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_gnt", int'(gnt), 0);
        chk("rst_mid_owner", int'(owner), 0);
        push_pkt(0, 1, 'h80, 1);
        push_pkt(2, 1, 'h90, 1);
        step(8);
        chk("rst_mid_drained", exp_q.size(), 0);

`ifdef ARB_WATCHDOG_EN
        // producer 1 dies after its first beat; watchdog frees the port for producer 2
        wr_cyc.delete();
        err_cyc.delete();
        c = cyc;
        push_pkt(1, 3, 'hB0, 1);
        push_pkt(2, 1, 'hC0, 1);
        step(2);
        dead[1] = 1'b1;
        step(24);
        chk("wd_err_count", err_cyc.size(), 1);
        if (err_cyc.size() > 0) chk("wd_err_cycle", err_cyc[0], c + 19);
        chk("wd_nwrites", wr_cyc.size(), 2);
        if (wr_cyc.size() > 1) chk("wd_next_grant_cycle", wr_cyc[1], c + 21);
        pq[1].delete();
        dead[1] = 1'b0;
`else
        chk("no_err_pulse", err_cyc.size(), 0);
`endif

        step(2);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
